// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states and baud divider calculation.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_START   = 3'd1,
        ST_DATA    = 3'd2,
        ST_PARITY  = 3'd3,
        ST_STOP    = 3'd4,
        ST_WAIT_HI = 3'd5
    } uart_state_t;

    // Clocks per oversample tick; clamped to 1 so a too-fast baud still elaborates.
    function automatic int uart_div(input int clk_freq, input int baud, input int oversample);
        int d;
        d = clk_freq / (baud * oversample);
        if (d < 1) d = 1;
        return d;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Free-running divider producing a one-cycle oversample tick every DIV clocks.
module uart_baud_gen #(
    parameter int DIV = 10
) (
    input  logic i_clk,
    input  logic i_rst_n,
    output logic o_tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] r_cnt;
    logic          w_wrap;

    assign w_wrap = (r_cnt == CW'(DIV - 1));

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (w_wrap) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_tick = w_wrap;

endmodule

// File: rtl/axis_uart_rx.sv
// Oversampling UART receiver (8N1, or 8E1 when AXIS_UART_RX_PARITY_EN is defined)
// feeding a single-entry AXI-Stream holding register with error pulses.
module axis_uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx_i,
    output logic [DATA_BITS-1:0] m_axis_tdata,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 parity_err,
    output logic                 busy
);

    // OVERSAMPLE must be even and >= 8; DATA_BITS must be >= 2.
    localparam int DIV   = uart_div(CLK_FREQ, BAUD, OVERSAMPLE);
    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam int BIT_W = $clog2(DATA_BITS + 1);

    logic                 w_tick;
    logic                 r_sync1;
    logic                 r_sync2;
    logic                 r_rxs_d;
    logic                 w_rxs;
    uart_state_t          r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic [BIT_W-1:0]     r_bit;
    logic [DATA_BITS-1:0] r_shift;
    logic                 w_half_end;
    logic                 w_bit_end;
    logic                 w_data_smp;
    logic                 w_stop_smp;
    logic                 w_ferr;
    logic                 w_perr;
    logic                 w_good;
    logic                 w_load;
    logic                 w_ovr;
    logic [DATA_BITS-1:0] r_tdata;
    logic                 r_tvalid;
    logic                 r_ferr;
    logic                 r_ovr;
    logic                 r_perr;
`ifdef AXIS_UART_RX_PARITY_EN
    logic                 r_par;
    logic                 w_par_smp;
`endif

    uart_baud_gen #(
        .DIV (DIV)
    ) u_baud (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .o_tick  (w_tick)
    );

    // Synchronizer and edge-detect history idle high so reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_rxs_d <= 1'b1;
        end else begin
            r_sync1 <= rx_i;
            r_sync2 <= r_sync1;
            r_rxs_d <= r_sync2;
        end
    end

    assign w_rxs      = r_sync2;
    assign w_half_end = w_tick && (r_cnt == CNT_W'(OVERSAMPLE / 2 - 1));
    assign w_bit_end  = w_tick && (r_cnt == CNT_W'(OVERSAMPLE - 1));
    assign w_data_smp = (r_state == ST_DATA) && w_bit_end;
    assign w_stop_smp = (r_state == ST_STOP) && w_bit_end;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_cnt <= '0;
                    r_bit <= '0;
                    if (r_rxs_d && !w_rxs) begin
                        r_state <= ST_START;
                    end
                end
                ST_START: begin
                    if (w_half_end) begin
                        r_cnt   <= '0;
                        r_state <= w_rxs ? ST_IDLE : ST_DATA;
                    end else if (w_tick) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (w_bit_end) begin
                        r_cnt <= '0;
                        if (r_bit == BIT_W'(DATA_BITS - 1)) begin
                            r_bit <= '0;
`ifdef AXIS_UART_RX_PARITY_EN
                            r_state <= ST_PARITY;
`else
                            r_state <= ST_STOP;
`endif
                        end else begin
                            r_bit <= r_bit + 1'b1;
                        end
                    end else if (w_tick) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
`ifdef AXIS_UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (w_bit_end) begin
                        r_cnt   <= '0;
                        r_state <= ST_STOP;
                    end else if (w_tick) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
`endif
                ST_STOP: begin
                    if (w_bit_end) begin
                        r_cnt   <= '0;
                        r_state <= w_rxs ? ST_IDLE : ST_WAIT_HI;
                    end else if (w_tick) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                // A held-low line (break) must return high before a new start edge counts.
                ST_WAIT_HI: begin
                    if (w_rxs) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Payload shift register, LSB arrives first.
    always_ff @(posedge clk) begin
        if (w_data_smp) begin
            r_shift <= {w_rxs, r_shift[DATA_BITS-1:1]};
        end
    end

`ifdef AXIS_UART_RX_PARITY_EN
    assign w_par_smp = (r_state == ST_PARITY) && w_bit_end;

    always_ff @(posedge clk) begin
        if (w_par_smp) begin
            r_par <= w_rxs;
        end
    end

    assign w_perr = w_stop_smp && (^{r_shift, r_par});
`else
    assign w_perr = 1'b0;
`endif

    // Any error drops the byte and masks the overrun indication.
    assign w_ferr = w_stop_smp && !w_rxs;
    assign w_good = w_stop_smp && w_rxs && !w_perr;
    assign w_load = w_good && (!r_tvalid || m_axis_tready);
    assign w_ovr  = w_good && r_tvalid && !m_axis_tready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_tdata  <= '0;
            r_tvalid <= 1'b0;
            r_ferr   <= 1'b0;
            r_ovr    <= 1'b0;
            r_perr   <= 1'b0;
        end else begin
            r_ferr <= w_ferr;
            r_ovr  <= w_ovr;
            r_perr <= w_perr;
            if (w_load) begin
                r_tdata  <= r_shift;
                r_tvalid <= 1'b1;
            end else if (m_axis_tready) begin
                r_tvalid <= 1'b0;
            end
        end
    end

    assign m_axis_tdata  = r_tdata;
    assign m_axis_tvalid = r_tvalid;
    assign frame_err     = r_ferr;
    assign overrun       = r_ovr;
    assign parity_err    = r_perr;
    assign busy          = (r_state != ST_IDLE);

endmodule

// File: tb/tb_axis_uart_rx.sv
// Bench for axis_uart_rx: directed corner cases, a frame table and randomized frames
// checked against a byte-queue reference model. Honours AXIS_UART_RX_PARITY_EN.
`timescale 1ns/1ps
module tb_axis_uart_rx;

    localparam int CLK_FREQ = 18_432_000;
    localparam int BAUD     = 115200;
    localparam int OS       = 16;
    localparam int DB       = 8;
    localparam int DIV      = CLK_FREQ / (BAUD * OS);
    localparam int BITT     = DIV * OS;
`ifdef AXIS_UART_RX_PARITY_EN
    localparam int HAS_PAR  = 1;
`else
    localparam int HAS_PAR  = 0;
`endif
    // Start-edge to tvalid: half a start bit plus data, parity and stop bits, plus sync/tick phase.
    localparam int LAT_NOM  = BITT / 2 + (DB + HAS_PAR + 1) * BITT;
    localparam int LAT_LO   = LAT_NOM - 10;
    localparam int LAT_HI   = LAT_NOM + 15;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          rx_i;
    logic          tready;
    logic [DB-1:0] tdata;
    logic          tvalid;
    logic          ferr;
    logic          ovr;
    logic          perr;
    logic          busy;

    axis_uart_rx #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD       (BAUD),
        .OVERSAMPLE (OS),
        .DATA_BITS  (DB)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rx_i          (rx_i),
        .m_axis_tdata  (tdata),
        .m_axis_tvalid (tvalid),
        .m_axis_tready (tready),
        .frame_err     (ferr),
        .overrun       (ovr),
        .parity_err    (perr),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_err    = 0;
    int         cyc = 0, vld_cycles = 0, ferr_cnt = 0, ovr_cnt = 0, perr_cnt = 0;
    int         stab_err = 0, rise_cyc = 0, ovr_cyc = 0;
    logic [7:0] rx_q[$];
    logic       prev_hold = 1'b0, prev_valid = 1'b0;
    logic [7:0] prev_data = 8'h00;

    // Inputs change only at posedge+1, so tvalid&&tready seen here is the next edge's handshake.
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (tvalid) vld_cycles <= vld_cycles + 1;
        if (tvalid && tready) rx_q.push_back(tdata);
        if (ferr) ferr_cnt <= ferr_cnt + 1;
        if (perr) perr_cnt <= perr_cnt + 1;
        if (ovr) begin
            ovr_cnt <= ovr_cnt + 1;
            ovr_cyc <= cyc + 1;
        end
        if (tvalid && !prev_valid) rise_cyc <= cyc + 1;
        if (rst_n && prev_hold && (!tvalid || tdata != prev_data)) stab_err <= stab_err + 1;
        prev_hold  <= rst_n && tvalid && !tready;
        prev_data  <= tdata;
        prev_valid <= tvalid;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", n_checks, n_err);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_rng(input string name, input int act, input int lo, input int hi);
        n_checks++;
        if (act < lo || act > hi) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    function automatic logic epar(input logic [7:0] d);
        return ^d;
    endfunction

    // Called and returns at posedge+1.
    task automatic drive_bit(input logic v, input int n);
        rx_i = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        drive_bit(1'b1, n);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_v, input int stop_len, input logic par_v);
        drive_bit(1'b0, BITT);
        for (int i = 0; i < DB; i++) drive_bit(d[i], BITT);
        if (HAS_PAR != 0) drive_bit(par_v, BITT);
        drive_bit(stop_v, stop_len);
        if (!stop_v) drive_bit(1'b1, BITT);
    endtask

    int b_rx, b_ferr, b_ovr, b_perr, b_vld, t0;

    task automatic snap();
        b_rx   = rx_q.size();
        b_ferr = ferr_cnt;
        b_ovr  = ovr_cnt;
        b_perr = perr_cnt;
        b_vld  = vld_cycles;
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop_ok;
        int         exp_rx;
        int         exp_ferr;
        logic [7:0] exp_byte;
    } vec_t;

    vec_t       vecs[6];
    logic [7:0] exp_q[$];
    int         exp_ferr, exp_perr;
    bit         rnd_run;

    initial begin
        vecs[0] = '{8'h00, 1'b1, 1, 0, 8'h00};
        vecs[1] = '{8'hFF, 1'b1, 1, 0, 8'hFF};
        vecs[2] = '{8'h80, 1'b1, 1, 0, 8'h80};
        vecs[3] = '{8'h01, 1'b0, 0, 1, 8'h00};
        vecs[4] = '{8'hC3, 1'b1, 1, 0, 8'hC3};
        vecs[5] = '{8'h5A, 1'b0, 0, 1, 8'h00};

        rst_n  = 1'b0;
        rx_i   = 1'b1;
        tready = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("reset_tvalid", tvalid, 1'b0);
        check("reset_tdata", tdata, 8'h00);
        check("reset_flags", {ferr, ovr, perr}, 3'b000);
        check("reset_busy", busy, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(50);

        // 1: single byte with tready high
        tready = 1'b1;
        snap();
        t0 = cyc;
        fork
            send_frame(8'hA5, 1'b1, BITT, epar(8'hA5));
            begin
                repeat (BITT * 4) @(posedge clk);
                #1;
                check("t1_busy_mid", busy, 1'b1);
            end
        join
        idle(300);
        check("t1_rx_count", rx_q.size() - b_rx, 1);
        check("t1_rx_data", rx_q[rx_q.size() - 1], 8'hA5);
        check("t1_valid_cycles", vld_cycles - b_vld, 1);
        check("t1_no_flags", (ferr_cnt - b_ferr) + (ovr_cnt - b_ovr) + (perr_cnt - b_perr), 0);
        check("t1_busy_end", busy, 1'b0);
        check_rng("t1_latency", rise_cyc - t0, LAT_LO, LAT_HI);

        // 2: overrun while holding register is full
        tready = 1'b0;
        snap();
        send_frame(8'h3C, 1'b1, BITT, epar(8'h3C));
        idle(100);
        t0 = cyc;
        send_frame(8'h7E, 1'b1, BITT, epar(8'h7E));
        idle(300);
        check("t2_tvalid_held", tvalid, 1'b1);
        check("t2_tdata_held", tdata, 8'h3C);
        check("t2_overrun_count", ovr_cnt - b_ovr, 1);
        check_rng("t2_overrun_time", ovr_cyc - t0, LAT_LO, LAT_HI);
        check("t2_stable", stab_err, 0);
        tready = 1'b1;
        idle(5);
        check("t2_tvalid_drop", tvalid, 1'b0);
        check("t2_rx_count", rx_q.size() - b_rx, 1);
        check("t2_rx_data", rx_q[rx_q.size() - 1], 8'h3C);

        // 3: stop bit low for two bit times, then a good byte
        snap();
        send_frame(8'h55, 1'b0, 2 * BITT, epar(8'h55));
        idle(300);
        check("t3_frame_err", ferr_cnt - b_ferr, 1);
        check("t3_no_valid", vld_cycles - b_vld, 0);
        check("t3_no_overrun", ovr_cnt - b_ovr, 0);
        send_frame(8'h12, 1'b1, BITT, epar(8'h12));
        idle(300);
        check("t3_rx_count", rx_q.size() - b_rx, 1);
        check("t3_rx_data", rx_q[rx_q.size() - 1], 8'h12);
        check("t3_ferr_total", ferr_cnt - b_ferr, 1);

        // 4: glitch shorter than half a bit
        snap();
        drive_bit(1'b0, 40);
        idle(300);
        check("t4_busy", busy, 1'b0);
        check("t4_no_valid", vld_cycles - b_vld, 0);
        check("t4_no_flags", (ferr_cnt - b_ferr) + (perr_cnt - b_perr), 0);

        // 5: reset during data bit 4
        snap();
        fork
            send_frame(8'hFF, 1'b1, BITT, epar(8'hFF));
            begin
                repeat (BITT * 5 + BITT / 2) @(posedge clk);
                #1;
                rst_n = 1'b0;
                @(posedge clk); #1;
                rst_n = 1'b1;
                @(negedge clk);
                check("t5_reset_tdata", tdata, 8'h00);
                check("t5_reset_outs", {tvalid, ferr, ovr, perr, busy}, 5'b0);
            end
        join
        idle(300);
        check("t5_after_busy", busy, 1'b0);
        check("t5_after_nothing", (rx_q.size() - b_rx) + (ferr_cnt - b_ferr), 0);
        send_frame(8'h81, 1'b1, BITT, epar(8'h81));
        idle(300);
        check("t5_rx_count", rx_q.size() - b_rx, 1);
        check("t5_rx_data", rx_q[rx_q.size() - 1], 8'h81);

`ifdef AXIS_UART_RX_PARITY_EN
        // 6: wrong then right even parity
        snap();
        send_frame(8'h07, 1'b1, BITT, 1'b0);
        idle(300);
        check("t6_parity_err", perr_cnt - b_perr, 1);
        check("t6_no_valid", vld_cycles - b_vld, 0);
        send_frame(8'h07, 1'b1, BITT, 1'b1);
        idle(300);
        check("t6_rx_count", rx_q.size() - b_rx, 1);
        check("t6_rx_data", rx_q[rx_q.size() - 1], 8'h07);
        check("t6_perr_total", perr_cnt - b_perr, 1);
`endif

        // Frame table
        for (int v = 0; v < 6; v++) begin
            snap();
            send_frame(vecs[v].data, vecs[v].stop_ok, BITT, epar(vecs[v].data));
            idle(300);
            check($sformatf("vec%0d_rx_count", v), rx_q.size() - b_rx, vecs[v].exp_rx);
            check($sformatf("vec%0d_ferr", v), ferr_cnt - b_ferr, vecs[v].exp_ferr);
            if (vecs[v].exp_rx == 1 && rx_q.size() > b_rx)
                check($sformatf("vec%0d_data", v), rx_q[rx_q.size() - 1], vecs[v].exp_byte);
        end

        // Randomized frames with random backpressure
        snap();
        exp_ferr = 0;
        exp_perr = 0;
        rnd_run  = 1'b1;
        fork
            begin
                for (int f = 0; f < 14; f++) begin
                    logic [7:0] d;
                    logic       bad_stop, bad_par;
                    d        = 8'($urandom);
                    bad_stop = ($urandom_range(0, 5) == 0);
                    bad_par  = (HAS_PAR != 0) && ($urandom_range(0, 5) == 0);
                    if (!bad_stop && !bad_par) exp_q.push_back(d);
                    exp_ferr += int'(bad_stop);
                    exp_perr += int'(bad_par);
                    send_frame(d, !bad_stop, bad_stop ? BITT + $urandom_range(0, BITT) : BITT,
                               epar(d) ^ bad_par);
                    idle($urandom_range(20, 200));
                end
                idle(300);
                rnd_run = 1'b0;
            end
            begin
                while (rnd_run) begin
                    @(posedge clk); #1;
                    tready = 1'($urandom_range(0, 1));
                end
            end
        join
        tready = 1'b1;
        idle(20);
        check("rnd_rx_count", rx_q.size() - b_rx, exp_q.size());
        for (int i = 0; i < exp_q.size() && (b_rx + i) < rx_q.size(); i++)
            check($sformatf("rnd_byte%0d", i), rx_q[b_rx + i], exp_q[i]);
        check("rnd_ferr", ferr_cnt - b_ferr, exp_ferr);
        check("rnd_perr", perr_cnt - b_perr, exp_perr);
        check("rnd_overrun", ovr_cnt - b_ovr, 0);
        check("rnd_stable", stab_err, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
